// File: rtl/mem_stage_if.sv
// Data-side Wishbone classic bus of the XYZ core: MEM stage is the master, data memory the slave.
interface mem_stage_if;
    logic [31:0] dwbm_addr_o;
    logic [31:0] dwbm_dat_o;
    logic [3:0]  dwbm_sel_o;
    logic        dwbm_cyc_o;
    logic        dwbm_stb_o;
    logic        dwbm_we_o;
    logic [31:0] dwbm_dat_i;
    logic        dwbm_ack_i;
    logic        dwbm_err_i;

    modport master (
        output dwbm_addr_o, dwbm_dat_o, dwbm_sel_o, dwbm_cyc_o, dwbm_stb_o, dwbm_we_o,
        input  dwbm_dat_i, dwbm_ack_i, dwbm_err_i
    );

    modport slave (
        input  dwbm_addr_o, dwbm_dat_o, dwbm_sel_o, dwbm_cyc_o, dwbm_stb_o, dwbm_we_o,
        output dwbm_dat_i, dwbm_ack_i, dwbm_err_i
    );
endinterface

// File: rtl/mem_stage.sv
// XYZ core MEM stage: Wishbone classic data master, load formatting, misaligned and
// bus-error traps, and the MEM/WB pipeline register feeding writeback.
module mem_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic        flush_i,
    input  logic [31:0] pc_mem_i,
    input  logic [31:0] pc4_mem_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] store_data_i,
    input  logic        mem_rd_i,
    input  logic        mem_wr_i,
    input  logic [1:0]  mem_size_i,
    input  logic        mem_unsigned_i,
    input  logic [4:0]  rd_i,
    input  logic        rf_we_i,
    input  logic [1:0]  mux_sel_i,
    input  logic        comp_i,
    input  logic [31:0] csr_data_i,
    input  logic [11:0] csr_addr_i,
    input  logic [1:0]  csr_op_i,
    input  logic        is_csr_i,
    input  logic        is_rs1_i,
    input  logic        is_mret_i,
    input  logic        is_trap_i,
    input  logic [3:0]  trap_code_i,
    mem_stage_if.master dwbm,
    output logic        stall_o,
    output logic [31:0] PC4_wb_o,
    output logic [31:0] PC_wb_o,
    output logic [31:0] data_or_alu_o,
    output logic [31:0] csr_data_wb_o,
    output logic [4:0]  rd_wb_o,
    output logic [11:0] csr_addr_wb_o,
    output logic [3:0]  trap_code_wb_o,
    output logic [1:0]  mux_sel_o,
    output logic [1:0]  csr_op_o,
    output logic        rf_we_wb_o,
    output logic        is_trap_wb_o,
    output logic        comp_o,
    output logic        is_mret_o,
    output logic        is_csr_wb_o,
    output logic        is_rs1_wb_o
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] pc;
        logic [31:0] data;
        logic [31:0] csr_data;
        logic [4:0]  rd;
        logic [11:0] csr_addr;
        logic [3:0]  trap_code;
        logic [1:0]  mux_sel;
        logic [1:0]  csr_op;
        logic        rf_we;
        logic        is_trap;
        logic        comp;
        logic        is_mret;
        logic        is_csr;
        logic        is_rs1;
    } wb_t;

    state_e      state_q, state_d;
    wb_t         wb_q, wb_d;

    logic        mem_op, misaligned, start;
    logic        bus_end, bus_ok, bus_err;
    logic        flushed_q, flushed_d;
    logic [31:0] addr_q, wdat_q;
    logic [3:0]  sel_q;
    logic        we_q, uns_q;
    logic [1:0]  size_q;
    logic [3:0]  sel_calc;
    logic [31:0] wdat_calc;
    logic [31:0] rdat, load_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        cyc, we;
    logic [31:0] addr_out, dat_out;
    logic [3:0]  sel_out;

    assign mem_op  = valid_i & (mem_rd_i | mem_wr_i) & ~is_trap_i & ~flush_i;
    assign bus_end = (state_q == BUSY) & (dwbm.dwbm_ack_i | dwbm.dwbm_err_i);
    assign bus_err = (state_q == BUSY) & dwbm.dwbm_err_i;
    assign bus_ok  = (state_q == BUSY) & dwbm.dwbm_ack_i & ~dwbm.dwbm_err_i;

    always_comb begin
        case (mem_size_i)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = alu_result_i[0];
            default: misaligned = |alu_result_i[1:0];
        endcase
    end

    // Gated with reset so a held-over request cannot re-raise cyc while reset is asserted.
    assign start = rst_i & (state_q == IDLE) & mem_op & ~misaligned;

    always_comb begin
        sel_calc  = 4'b1111;
        wdat_calc = store_data_i;
        case (mem_size_i)
            2'b00: begin
                sel_calc  = 4'b0001 << alu_result_i[1:0];
                wdat_calc = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                sel_calc  = 4'b0011 << alu_result_i[1:0];
                wdat_calc = {2{store_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Load lane selection uses the latched address/size since the bus answers in a later cycle.
    always_comb begin
        rdat    = dwbm.dwbm_dat_i;
        ld_byte = rdat[7:0];
        case (addr_q[1:0])
            2'd1:    ld_byte = rdat[15:8];
            2'd2:    ld_byte = rdat[23:16];
            2'd3:    ld_byte = rdat[31:24];
            default: ld_byte = rdat[7:0];
        endcase
        ld_half = addr_q[1] ? rdat[31:16] : rdat[15:0];
        case (size_q)
            2'b00:   load_data = uns_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   load_data = uns_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: load_data = rdat;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = BUSY;
            BUSY:    if (bus_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cyc      = 1'b0;
        we       = 1'b0;
        addr_out = addr_q;
        dat_out  = wdat_q;
        sel_out  = sel_q;
        stall_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cyc      = 1'b1;
                    we       = mem_wr_i;
                    addr_out = alu_result_i;
                    dat_out  = wdat_calc;
                    sel_out  = sel_calc;
                    stall_o  = 1'b1;
                end
            end
            BUSY: begin
                cyc     = 1'b1;
                we      = we_q;
                stall_o = ~(dwbm.dwbm_ack_i | dwbm.dwbm_err_i);
            end
            default: ;
        endcase
    end

    assign dwbm.dwbm_cyc_o  = cyc;
    assign dwbm.dwbm_stb_o  = cyc;
    assign dwbm.dwbm_we_o   = we;
    assign dwbm.dwbm_addr_o = addr_out;
    assign dwbm.dwbm_dat_o  = dat_out;
    assign dwbm.dwbm_sel_o  = sel_out;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            addr_q <= '0;
            wdat_q <= '0;
            sel_q  <= '0;
            we_q   <= 1'b0;
            size_q <= '0;
            uns_q  <= 1'b0;
        end else if (start) begin
            addr_q <= alu_result_i;
            wdat_q <= wdat_calc;
            sel_q  <= sel_calc;
            we_q   <= mem_wr_i;
            size_q <= mem_size_i;
            uns_q  <= mem_unsigned_i;
        end
    end

    // A flush during a bus cycle cannot abort it, so remember it until the cycle ends.
    assign flushed_d = (state_q == BUSY) & ~bus_end & (flushed_q | flush_i);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            flushed_q <= 1'b0;
        end else begin
            flushed_q <= flushed_d;
        end
    end

    always_comb begin
        wb_d.pc4       = pc4_mem_i;
        wb_d.pc        = pc_mem_i;
        wb_d.data      = alu_result_i;
        wb_d.csr_data  = csr_data_i;
        wb_d.rd        = rd_i;
        wb_d.csr_addr  = csr_addr_i;
        wb_d.trap_code = trap_code_i;
        wb_d.mux_sel   = mux_sel_i;
        wb_d.csr_op    = csr_op_i;
        wb_d.rf_we     = rf_we_i;
        wb_d.is_trap   = is_trap_i;
        wb_d.comp      = comp_i;
        wb_d.is_mret   = is_mret_i;
        wb_d.is_csr    = is_csr_i;
        wb_d.is_rs1    = is_rs1_i;
        if (!is_trap_i) begin
            if (mem_op && misaligned) begin
                wb_d.is_trap   = 1'b1;
                wb_d.rf_we     = 1'b0;
                wb_d.trap_code = mem_wr_i ? 4'd6 : 4'd4;
            end else if (bus_err) begin
                wb_d.is_trap   = 1'b1;
                wb_d.rf_we     = 1'b0;
                wb_d.trap_code = we_q ? 4'd7 : 4'd5;
            end else if (bus_ok && !we_q) begin
                wb_d.data = load_data;
            end
        end
        if (!valid_i || flush_i || flushed_q) begin
            wb_d.rf_we   = 1'b0;
            wb_d.is_trap = 1'b0;
            wb_d.is_csr  = 1'b0;
            wb_d.is_mret = 1'b0;
            wb_d.comp    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wb_q <= '0;
        end else if (!stall_o) begin
            wb_q <= wb_d;
        end
    end

    assign PC4_wb_o       = wb_q.pc4;
    assign PC_wb_o        = wb_q.pc;
    assign data_or_alu_o  = wb_q.data;
    assign csr_data_wb_o  = wb_q.csr_data;
    assign rd_wb_o        = wb_q.rd;
    assign csr_addr_wb_o  = wb_q.csr_addr;
    assign trap_code_wb_o = wb_q.trap_code;
    assign mux_sel_o      = wb_q.mux_sel;
    assign csr_op_o       = wb_q.csr_op;
    assign rf_we_wb_o     = wb_q.rf_we;
    assign is_trap_wb_o   = wb_q.is_trap;
    assign comp_o         = wb_q.comp;
    assign is_mret_o      = wb_q.is_mret;
    assign is_csr_wb_o    = wb_q.is_csr;
    assign is_rs1_wb_o    = wb_q.is_rs1;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: the Wishbone slave is driven by hand, step by step.
module tb_mem_stage;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        valid_i, flush_i;
    logic [31:0] pc_mem_i, pc4_mem_i, alu_result_i, store_data_i;
    logic        mem_rd_i, mem_wr_i, mem_unsigned_i;
    logic [1:0]  mem_size_i;
    logic [4:0]  rd_i;
    logic        rf_we_i, comp_i;
    logic [1:0]  mux_sel_i;
    logic [31:0] csr_data_i;
    logic [11:0] csr_addr_i;
    logic [1:0]  csr_op_i;
    logic        is_csr_i, is_rs1_i, is_mret_i, is_trap_i;
    logic [3:0]  trap_code_i;

    logic        stall_o;
    logic [31:0] PC4_wb_o, PC_wb_o, data_or_alu_o, csr_data_wb_o;
    logic [4:0]  rd_wb_o;
    logic [11:0] csr_addr_wb_o;
    logic [3:0]  trap_code_wb_o;
    logic [1:0]  mux_sel_o, csr_op_o;
    logic        rf_we_wb_o, is_trap_wb_o, comp_o, is_mret_o, is_csr_wb_o, is_rs1_wb_o;

    int nAsserts = 0;
    int nFails = 0;
    int stallCycles = 0;

    mem_stage_if bus();

    mem_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .flush_i(flush_i),
        .pc_mem_i(pc_mem_i), .pc4_mem_i(pc4_mem_i), .alu_result_i(alu_result_i),
        .store_data_i(store_data_i), .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i),
        .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i), .rd_i(rd_i),
        .rf_we_i(rf_we_i), .mux_sel_i(mux_sel_i), .comp_i(comp_i),
        .csr_data_i(csr_data_i), .csr_addr_i(csr_addr_i), .csr_op_i(csr_op_i),
        .is_csr_i(is_csr_i), .is_rs1_i(is_rs1_i), .is_mret_i(is_mret_i),
        .is_trap_i(is_trap_i), .trap_code_i(trap_code_i), .dwbm(bus),
        .stall_o(stall_o), .PC4_wb_o(PC4_wb_o), .PC_wb_o(PC_wb_o),
        .data_or_alu_o(data_or_alu_o), .csr_data_wb_o(csr_data_wb_o),
        .rd_wb_o(rd_wb_o), .csr_addr_wb_o(csr_addr_wb_o),
        .trap_code_wb_o(trap_code_wb_o), .mux_sel_o(mux_sel_o), .csr_op_o(csr_op_o),
        .rf_we_wb_o(rf_we_wb_o), .is_trap_wb_o(is_trap_wb_o), .comp_o(comp_o),
        .is_mret_o(is_mret_o), .is_csr_wb_o(is_csr_wb_o), .is_rs1_wb_o(is_rs1_wb_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected) else begin
            nFails++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic setIdle();
        valid_i = 1'b0; flush_i = 1'b0;
        pc_mem_i = 32'h0; pc4_mem_i = 32'h4; alu_result_i = 32'h0; store_data_i = 32'h0;
        mem_rd_i = 1'b0; mem_wr_i = 1'b0; mem_size_i = 2'b10; mem_unsigned_i = 1'b0;
        rd_i = 5'd0; rf_we_i = 1'b0; mux_sel_i = 2'b00; comp_i = 1'b0;
        csr_data_i = 32'h0; csr_addr_i = 12'h0; csr_op_i = 2'b00;
        is_csr_i = 1'b0; is_rs1_i = 1'b0; is_mret_i = 1'b0;
        is_trap_i = 1'b0; trap_code_i = 4'd0;
    endtask

    task automatic applyStimulus(input logic isLoad, input logic isStore, input logic [1:0] size,
                                 input logic uns, input logic [31:0] addr,
                                 input logic [31:0] sdata, input logic rfWe, input logic [4:0] rd);
        setIdle();
        valid_i = 1'b1;
        pc_mem_i = 32'h80; pc4_mem_i = 32'h84;
        mem_rd_i = isLoad; mem_wr_i = isStore; mem_size_i = size; mem_unsigned_i = uns;
        alu_result_i = addr; store_data_i = sdata; rf_we_i = rfWe; rd_i = rd;
    endtask

    task automatic nextCycle();
        @(posedge clk_i);
        #2;
    endtask

    initial begin
        setIdle();
        bus.dwbm_dat_i = 32'h0; bus.dwbm_ack_i = 1'b0; bus.dwbm_err_i = 1'b0;
        #3;
        checkOutput("rst_cyc", 32'(bus.dwbm_cyc_o), 32'd0);
        checkOutput("rst_stb", 32'(bus.dwbm_stb_o), 32'd0);
        checkOutput("rst_we", 32'(bus.dwbm_we_o), 32'd0);
        checkOutput("rst_sel", 32'(bus.dwbm_sel_o), 32'd0);
        checkOutput("rst_addr", bus.dwbm_addr_o, 32'd0);
        checkOutput("rst_stall", 32'(stall_o), 32'd0);
        checkOutput("rst_rf_we", 32'(rf_we_wb_o), 32'd0);
        checkOutput("rst_data", data_or_alu_o, 32'd0);
        @(posedge clk_i);
        #2;
        rst_i = 1'b1;

        // Non-memory instruction: straight through in one cycle
        nextCycle();
        applyStimulus(1'b0, 1'b0, 2'b10, 1'b0, 32'h55AA, 32'h0, 1'b1, 5'd7);
        pc_mem_i = 32'h40; pc4_mem_i = 32'h44;
        csr_addr_i = 12'h305; csr_data_i = 32'hA5A5; mux_sel_i = 2'b10; comp_i = 1'b1; is_csr_i = 1'b1;
        #1;
        checkOutput("alu_stall", 32'(stall_o), 32'd0);
        checkOutput("alu_cyc", 32'(bus.dwbm_cyc_o), 32'd0);

        // LW 0x100
        nextCycle();
        checkOutput("alu_data", data_or_alu_o, 32'h55AA);
        checkOutput("alu_rf_we", 32'(rf_we_wb_o), 32'd1);
        checkOutput("alu_rd", 32'(rd_wb_o), 32'd7);
        checkOutput("alu_pc", PC_wb_o, 32'h40);
        checkOutput("alu_pc4", PC4_wb_o, 32'h44);
        checkOutput("alu_csr_addr", 32'(csr_addr_wb_o), 32'h305);
        checkOutput("alu_csr_data", csr_data_wb_o, 32'hA5A5);
        checkOutput("alu_mux_sel", 32'(mux_sel_o), 32'd2);
        checkOutput("alu_comp", 32'(comp_o), 32'd1);
        checkOutput("alu_is_csr", 32'(is_csr_wb_o), 32'd1);
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1, 5'd5);
        #1;
        checkOutput("lw_cyc", 32'(bus.dwbm_cyc_o), 32'd1);
        checkOutput("lw_stb", 32'(bus.dwbm_stb_o), 32'd1);
        checkOutput("lw_stall", 32'(stall_o), 32'd1);
        checkOutput("lw_addr", bus.dwbm_addr_o, 32'h100);
        checkOutput("lw_sel", 32'(bus.dwbm_sel_o), 32'hF);
        checkOutput("lw_we", 32'(bus.dwbm_we_o), 32'd0);
        nextCycle();
        bus.dwbm_ack_i = 1'b1; bus.dwbm_dat_i = 32'hDEADBEEF;
        #1;
        checkOutput("lw_ack_stall", 32'(stall_o), 32'd0);
        checkOutput("lw_ack_cyc", 32'(bus.dwbm_cyc_o), 32'd1);

        // LB 0x103
        nextCycle();
        bus.dwbm_ack_i = 1'b0;
        checkOutput("lw_data", data_or_alu_o, 32'hDEADBEEF);
        checkOutput("lw_rf_we", 32'(rf_we_wb_o), 32'd1);
        checkOutput("lw_rd", 32'(rd_wb_o), 32'd5);
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 1'b1, 5'd6);
        #1;
        checkOutput("lb_sel", 32'(bus.dwbm_sel_o), 32'h8);
        checkOutput("lb_cyc", 32'(bus.dwbm_cyc_o), 32'd1);
        nextCycle();
        bus.dwbm_ack_i = 1'b1; bus.dwbm_dat_i = 32'h80FF0000;
        nextCycle();
        bus.dwbm_ack_i = 1'b0;
        checkOutput("lb_data", data_or_alu_o, 32'hFFFFFF80);
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 1'b1, 5'd6);
        nextCycle();
        bus.dwbm_ack_i = 1'b1; bus.dwbm_dat_i = 32'h80FF0000;
        nextCycle();
        bus.dwbm_ack_i = 1'b0;
        checkOutput("lbu_data", data_or_alu_o, 32'h00000080);

        // LH 0x102
        applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 1'b1, 5'd8);
        #1;
        checkOutput("lh_sel", 32'(bus.dwbm_sel_o), 32'hC);
        nextCycle();
        bus.dwbm_ack_i = 1'b1; bus.dwbm_dat_i = 32'hF00D1234;
        nextCycle();
        bus.dwbm_ack_i = 1'b0;
        checkOutput("lh_data", data_or_alu_o, 32'hFFFFF00D);

        // SH 0x202 with three wait states
        applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h1234ABCD, 1'b0, 5'd0);
        #1;
        checkOutput("sh_dat", bus.dwbm_dat_o, 32'hABCDABCD);
        checkOutput("sh_sel", 32'(bus.dwbm_sel_o), 32'hC);
        checkOutput("sh_we", 32'(bus.dwbm_we_o), 32'd1);
        stallCycles = 0;
        if (stall_o) stallCycles++;
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            if (stall_o) stallCycles++;
            checkOutput("sh_wait_dat", bus.dwbm_dat_o, 32'hABCDABCD);
            checkOutput("sh_wait_addr", bus.dwbm_addr_o, 32'h202);
            checkOutput("sh_wait_we", 32'(bus.dwbm_we_o), 32'd1);
        end
        nextCycle();
        bus.dwbm_ack_i = 1'b1;
        #1;
        if (stall_o) stallCycles++;
        checkOutput("sh_stall_cycles", 32'(stallCycles), 32'd4);

        // LW 0x101 misaligned
        nextCycle();
        bus.dwbm_ack_i = 1'b0;
        checkOutput("sh_is_trap", 32'(is_trap_wb_o), 32'd0);
        checkOutput("sh_data", data_or_alu_o, 32'h202);
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 1'b1, 5'd9);
        #1;
        checkOutput("lw_mis_cyc", 32'(bus.dwbm_cyc_o), 32'd0);
        checkOutput("lw_mis_stall", 32'(stall_o), 32'd0);
        nextCycle();
        checkOutput("lw_mis_trap", 32'(is_trap_wb_o), 32'd1);
        checkOutput("lw_mis_code", 32'(trap_code_wb_o), 32'd4);
        checkOutput("lw_mis_rf_we", 32'(rf_we_wb_o), 32'd0);

        // SH 0x201 misaligned
        applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 32'h201, 32'h0, 1'b0, 5'd0);
        #1;
        checkOutput("sh_mis_cyc", 32'(bus.dwbm_cyc_o), 32'd0);
        nextCycle();
        checkOutput("sh_mis_code", 32'(trap_code_wb_o), 32'd6);

        // SW 0x300, error in first bus cycle
        applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h300, 32'hCAFEF00D, 1'b0, 5'd0);
        #1;
        checkOutput("sw_dat", bus.dwbm_dat_o, 32'hCAFEF00D);
        checkOutput("sw_sel", 32'(bus.dwbm_sel_o), 32'hF);
        nextCycle();
        bus.dwbm_err_i = 1'b1;
        #1;
        checkOutput("sw_err_stall", 32'(stall_o), 32'd0);
        nextCycle();
        bus.dwbm_err_i = 1'b0;
        checkOutput("sw_err_trap", 32'(is_trap_wb_o), 32'd1);
        checkOutput("sw_err_code", 32'(trap_code_wb_o), 32'd7);

        // LW 0x104, ack and err together
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 1'b1, 5'd3);
        nextCycle();
        bus.dwbm_ack_i = 1'b1; bus.dwbm_err_i = 1'b1;
        nextCycle();
        bus.dwbm_ack_i = 1'b0; bus.dwbm_err_i = 1'b0;
        checkOutput("ackerr_code", 32'(trap_code_wb_o), 32'd5);
        checkOutput("ackerr_trap", 32'(is_trap_wb_o), 32'd1);
        checkOutput("ackerr_rf_we", 32'(rf_we_wb_o), 32'd0);

        // Upstream trap passes through with no bus access
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h110, 32'h0, 1'b0, 5'd0);
        is_trap_i = 1'b1; trap_code_i = 4'd2;
        #1;
        checkOutput("uptrap_cyc", 32'(bus.dwbm_cyc_o), 32'd0);
        nextCycle();
        checkOutput("uptrap_trap", 32'(is_trap_wb_o), 32'd1);
        checkOutput("uptrap_code", 32'(trap_code_wb_o), 32'd2);

        // LW 0x108 flushed while BUSY
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h108, 32'h0, 1'b1, 5'd4);
        nextCycle();
        flush_i = 1'b1;
        #1;
        checkOutput("flush_cyc", 32'(bus.dwbm_cyc_o), 32'd1);
        checkOutput("flush_stall", 32'(stall_o), 32'd1);
        nextCycle();
        flush_i = 1'b0; bus.dwbm_ack_i = 1'b1; bus.dwbm_dat_i = 32'h11112222;
        #1;
        checkOutput("flush_ack_stall", 32'(stall_o), 32'd0);
        nextCycle();
        bus.dwbm_ack_i = 1'b0;
        checkOutput("flush_rf_we", 32'(rf_we_wb_o), 32'd0);
        checkOutput("flush_trap", 32'(is_trap_wb_o), 32'd0);

        // Invalid slot becomes a bubble
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h120, 32'h0, 1'b1, 5'd2);
        valid_i = 1'b0; is_csr_i = 1'b1;
        #1;
        checkOutput("inv_cyc", 32'(bus.dwbm_cyc_o), 32'd0);
        nextCycle();
        checkOutput("inv_rf_we", 32'(rf_we_wb_o), 32'd0);
        checkOutput("inv_is_csr", 32'(is_csr_wb_o), 32'd0);
        checkOutput("inv_pc", PC_wb_o, 32'h80);

        // Reset in the middle of an access
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h10C, 32'h0, 1'b1, 5'd1);
        nextCycle();
        #1;
        checkOutput("rstmid_busy_cyc", 32'(bus.dwbm_cyc_o), 32'd1);
        checkOutput("rstmid_busy_stall", 32'(stall_o), 32'd1);
        rst_i = 1'b0;
        #1;
        checkOutput("rstmid_cyc", 32'(bus.dwbm_cyc_o), 32'd0);
        checkOutput("rstmid_stall", 32'(stall_o), 32'd0);
        checkOutput("rstmid_addr", bus.dwbm_addr_o, 32'd0);
        checkOutput("rstmid_pc_wb", PC_wb_o, 32'd0);
        setIdle();
        nextCycle();
        rst_i = 1'b1;
        nextCycle();
        checkOutput("post_rst_cyc", 32'(bus.dwbm_cyc_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
